uart_rx_dec_ctrl: RTL and testbench
===================================

UART_RX_DEC_CTRL -- requirements
Module: uart_rx_dec_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with the ports below.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL provide the following ports.
- en_i  input  1  decrypt enable.
- fifo_empty_i  input  1  ciphertext FIFO empty.
- ct_data_i  input  8  FIFO dout; valid the cycle after pop.
- pop_o  output  1  FIFO pop strobe.
- ks_ready_i  input  1  Trivium initialised, keystream available.
- ks_req_o  output  1  keystream byte request (level).
- ks_valid_i  input  1  keystream byte valid.
- ks_byte_i  input  8  keystream byte.
- pt_data_o  output  8  plaintext byte.
- pt_valid_o  output  1  plaintext valid.
- pt_ready_i  input  1  downstream ready.
- pe_i, fe_i, bi_i  input  1 each  line-status error pulses from the deserializer.
- err_clr_i  input  1  clear sticky error flags.
- err_flags_o  output  3  sticky {bi,fe,pe}.
- err_cnt_o  output  8  error event count (see Configuration).
- byte_cnt_o  output  16  delivered plaintext byte count.
- busy_o  output  1  FSM not in IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, POP, CAPT, KS and OUT.
REQ-004 In IDLE, the FSM SHALL go to POP when en_i=1, ks_ready_i=1 and fifo_empty_i=0 are all true in the same cycle; otherwise it SHALL stay in IDLE.
REQ-005 pop_o SHALL be high for exactly the one cycle spent in POP, after which the FSM SHALL go to CAPT; this gives exactly one pop per byte.
REQ-006 In CAPT, the block SHALL register ct_data_i into a ciphertext register and go to KS.
REQ-007 In KS, ks_req_o SHALL be high (combinational decode of state).
- A transfer occurs when ks_req_o=1 and ks_valid_i=1 in the same cycle.
- On transfer: pt_data_o <= ciphertext register XOR ks_byte_i, and the FSM goes to OUT.
- ks_req_o SHALL be low in every state other than KS.
REQ-008 In OUT, pt_valid_o SHALL be high and pt_data_o SHALL be held stable until pt_ready_i=1.
- On handshake: byte_cnt_o increments by 1, wrapping 0xFFFF->0x0000, and the FSM goes to IDLE.
REQ-009 Minimum latency from IDLE exit to pt_valid_o SHALL be 3 cycles (POP, CAPT, KS with ks_valid_i already high); peak throughput SHALL be 1 byte per 5 cycles.
REQ-010 Deassertion of en_i or ks_ready_i outside IDLE SHALL NOT abort the byte in flight; it only blocks the next IDLE->POP transition.
REQ-011 fifo_empty_i SHALL be ignored outside IDLE.
REQ-012 busy_o SHALL equal (state != IDLE).
REQ-013 Error flags SHALL be sticky.
- Each err_flags_o bit is set on its pulse input and cleared by err_clr_i.
- If set and clear occur in the same cycle, set wins.
- Error inputs SHALL NOT alter the FSM sequence.

Reset
REQ-014 While rst=1, the FSM SHALL enter IDLE, including from mid-byte; the partial byte is discarded and no pop is issued.
REQ-015 While rst=1, the following outputs SHALL be 0: pop_o, ks_req_o, pt_valid_o, pt_data_o, err_flags_o, err_cnt_o, byte_cnt_o, busy_o.
REQ-016 rst SHALL take priority over every other input.

Configuration
REQ-017 With the macro RX_DEC_ERRCNT_EN defined, err_cnt_o SHALL work as follows.
- It increments by 1 in each cycle where any of pe_i, fe_i or bi_i is 1.
- It saturates at 255.
- It clears on err_clr_i; increment wins on a same-cycle conflict.
REQ-018 With RX_DEC_ERRCNT_EN undefined, err_cnt_o SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-019 Single byte: ct=0xA5, ks_byte=0x3C with ks_valid held 1, pt_ready=1 -> one pop_o pulse, pt_data_o=0x99 with pt_valid_o 3 cycles after IDLE exit, byte_cnt_o=1.
REQ-020 Backpressure: hold pt_ready_i=0 for 10 cycles -> pt_valid_o and pt_data_o stable throughout, no further pop_o, byte_cnt_o updates only on the handshake.
REQ-021 Keystream stall: ks_valid_i low for 7 cycles in KS -> ks_req_o stays high all 7 cycles, transfer on the 8th, correct XOR result.
REQ-022 Gating: fifo_empty_i=0 with ks_ready_i=0, or en_i=0 -> zero pops; drop en_i during KS -> byte completes, then the FSM idles.
REQ-023 Reset mid-byte: assert rst in CAPT -> next cycle all outputs are 0 and the FSM is in IDLE; after release the next byte decrypts correctly.
REQ-024 Errors: pe_i and fe_i pulses plus err_clr_i in the same cycle as a bi_i pulse -> err_flags_o=3'b100.
- With RX_DEC_ERRCNT_EN: 300 error cycles -> err_cnt_o=255.
- Without RX_DEC_ERRCNT_EN: err_cnt_o=0.

Source files
------------

// File: rtl/uart_rx_dec_ctrl_if.sv
// Byte-stream handshakes of the UART receive decrypt controller:
// ciphertext FIFO, Trivium keystream source and plaintext sink.
interface uart_rx_dec_ctrl_if;
   logic       fifo_empty_i;
   logic [7:0] ct_data_i;
   logic       pop_o;
   logic       ks_ready_i;
   logic       ks_req_o;
   logic       ks_valid_i;
   logic [7:0] ks_byte_i;
   logic [7:0] pt_data_o;
   logic       pt_valid_o;
   logic       pt_ready_i;

   modport master (
      input  fifo_empty_i, ct_data_i, ks_ready_i, ks_valid_i, ks_byte_i, pt_ready_i,
      output pop_o, ks_req_o, pt_data_o, pt_valid_o
   );

   modport slave (
      output fifo_empty_i, ct_data_i, ks_ready_i, ks_valid_i, ks_byte_i, pt_ready_i,
      input  pop_o, ks_req_o, pt_data_o, pt_valid_o
   );
endinterface

// File: rtl/uart_rx_dec_ctrl.sv
// Pops one ciphertext byte, XORs it with one keystream byte, delivers plaintext.
// Optional error-event counter enabled by defining RX_DEC_ERRCNT_EN.
module uart_rx_dec_ctrl (
   input  logic                      clk,
   input  logic                      rst,
   uart_rx_dec_ctrl_if.master        bus,
   input  logic                      en_i,
   input  logic                      pe_i,
   input  logic                      fe_i,
   input  logic                      bi_i,
   input  logic                      err_clr_i,
   output logic [2:0]                err_flags_o,
   output logic [7:0]                err_cnt_o,
   output logic [15:0]               byte_cnt_o,
   output logic                      busy_o
);

   typedef enum logic [2:0] {IDLE, POP, CAPT, KS, OUT} state_t;

   state_t      state, state_nxt;
   logic [7:0]  ct_q;
   logic [7:0]  pt_q;
   logic [2:0]  flags_q;
   logic [15:0] cnt_q;
   logic        pop, ks_req, pt_valid, busy;
   logic        xfer, hs;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (en_i && bus.ks_ready_i && !bus.fifo_empty_i) state_nxt = POP;
         POP:  state_nxt = CAPT;
         CAPT: state_nxt = KS;
         KS:   if (bus.ks_valid_i) state_nxt = OUT;
         OUT:  if (bus.pt_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are masked by rst so they read 0 even before the reset edge lands.
   always_comb begin
      pop      = 1'b0;
      ks_req   = 1'b0;
      pt_valid = 1'b0;
      busy     = 1'b0;
      if (!rst) begin
         pop      = (state == POP);
         ks_req   = (state == KS);
         pt_valid = (state == OUT);
         busy     = (state != IDLE);
      end
   end

   assign xfer = ks_req & bus.ks_valid_i;
   assign hs   = pt_valid & bus.pt_ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         ct_q    <= '0;
         pt_q    <= '0;
         cnt_q   <= '0;
         flags_q <= '0;
      end else begin
         if (state == CAPT) ct_q <= bus.ct_data_i;
         if (xfer)          pt_q <= ct_q ^ bus.ks_byte_i;
         if (hs)            cnt_q <= cnt_q + 16'd1;
         flags_q <= (flags_q & ~{3{err_clr_i}}) | {bi_i, fe_i, pe_i};
      end
   end

`ifdef RX_DEC_ERRCNT_EN
   logic [7:0] ecnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ecnt_q <= '0;
      end else if (pe_i || fe_i || bi_i) begin
         if (ecnt_q != '1) ecnt_q <= ecnt_q + 8'd1;
      end else if (err_clr_i) begin
         ecnt_q <= '0;
      end
   end

   assign err_cnt_o = rst ? '0 : ecnt_q;
`else
   assign err_cnt_o = '0;
`endif

   assign bus.pop_o      = pop;
   assign bus.ks_req_o   = ks_req;
   assign bus.pt_valid_o = pt_valid;
   assign bus.pt_data_o  = rst ? '0 : pt_q;
   assign err_flags_o    = rst ? '0 : flags_q;
   assign byte_cnt_o     = rst ? '0 : cnt_q;
   assign busy_o         = busy;

endmodule

// File: tb/tb_uart_rx_dec_ctrl.sv
// Directed + randomized bench for uart_rx_dec_ctrl; a transaction-level
// scoreboard (FIFO queue, in-flight ciphertext, expected plaintext) predicts data.
module tb_uart_rx_dec_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_i, pe_i, fe_i, bi_i, err_clr_i;
   logic [2:0]  err_flags_o;
   logic [7:0]  err_cnt_o;
   logic [15:0] byte_cnt_o;
   logic        busy_o;

   always #5 clk = ~clk;

   uart_rx_dec_ctrl_if bus ();

   uart_rx_dec_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .en_i        (en_i),
      .pe_i        (pe_i),
      .fe_i        (fe_i),
      .bi_i        (bi_i),
      .err_clr_i   (err_clr_i),
      .err_flags_o (err_flags_o),
      .err_cnt_o   (err_cnt_o),
      .byte_cnt_o  (byte_cnt_o),
      .busy_o      (busy_o)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  fifo_q[$];
   logic [7:0]  ct_fly[$];
   logic [7:0]  pt_exp[$];
   logic [15:0] exp_cnt = '0;
   bit          rnd_traffic = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      bus.fifo_empty_i = 1'b0;
   endtask

   // One clock: log DUT events into the scoreboard, advance, then drive inputs.
   task automatic cyc();
      logic       pop_s, xfer_s, hs_s;
      logic [7:0] popped, e, c;
      pop_s  = bus.pop_o;
      xfer_s = bus.ks_req_o & bus.ks_valid_i;
      hs_s   = bus.pt_valid_o & bus.pt_ready_i;
      popped = 8'h00;
      chk("exclusive", 32'($countones({bus.pop_o, bus.ks_req_o, bus.pt_valid_o}) <= 1), 32'd1);
      if (hs_s) begin
         if (pt_exp.size() != 0) e = pt_exp.pop_front(); else e = 'x;
         chk("pt_data", 32'(bus.pt_data_o), 32'(e));
         exp_cnt = exp_cnt + 16'd1;
      end
      if (xfer_s) begin
         if (ct_fly.size() != 0) c = ct_fly.pop_front(); else c = 'x;
         pt_exp.push_back(c ^ bus.ks_byte_i);
      end
      if (pop_s) begin
         if (fifo_q.size() != 0) popped = fifo_q.pop_front(); else popped = 'x;
         ct_fly.push_back(popped);
      end
      @(posedge clk);
      #1;
      bus.ct_data_i    = pop_s ? popped : 8'($urandom);
      bus.fifo_empty_i = (fifo_q.size() == 0);
      if (rnd_traffic) begin
         bus.ks_valid_i = ($urandom_range(0, 3) != 0);
         bus.pt_ready_i = ($urandom_range(0, 2) != 0);
         bus.ks_byte_i  = 8'($urandom);
      end
      chk("byte_cnt", 32'(byte_cnt_o), 32'(exp_cnt));
   endtask

   task automatic wait_quiet(input int unsigned budget, input string tag);
      int unsigned n = 0;
      while ((busy_o || ct_fly.size() != 0 || pt_exp.size() != 0 ||
              (en_i && bus.ks_ready_i && fifo_q.size() != 0)) && n < budget) begin
         cyc();
         n++;
      end
      chk(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pop"},     32'(bus.pop_o),      32'd0);
      chk({tag, "_ks_req"},  32'(bus.ks_req_o),   32'd0);
      chk({tag, "_pt_vld"},  32'(bus.pt_valid_o), 32'd0);
      chk({tag, "_pt_data"}, 32'(bus.pt_data_o),  32'd0);
      chk({tag, "_flags"},   32'(err_flags_o),    32'd0);
      chk({tag, "_err_cnt"}, 32'(err_cnt_o),      32'd0);
      chk({tag, "_byte_cnt"},32'(byte_cnt_o),     32'd0);
      chk({tag, "_busy"},    32'(busy_o),         32'd0);
   endtask

   initial begin
      logic [7:0]  hold;
      logic [15:0] cnt_before;
      logic [2:0]  exp_flags;
      logic [2:0]  ev;
      int unsigned exp_ec;

      bus.fifo_empty_i = 1'b1;
      bus.ct_data_i    = '0;
      bus.ks_ready_i   = 1'b0;
      bus.ks_valid_i   = 1'b0;
      bus.ks_byte_i    = '0;
      bus.pt_ready_i   = 1'b0;
      en_i = 1'b0; pe_i = 1'b0; fe_i = 1'b0; bi_i = 1'b0; err_clr_i = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      cyc();

      // Single byte: A5 ^ 3C = 99, valid three cycles after leaving IDLE
      en_i = 1'b1; bus.ks_ready_i = 1'b1; bus.ks_valid_i = 1'b1;
      bus.pt_ready_i = 1'b1; bus.ks_byte_i = 8'h3C;
      push(8'hA5);
      chk("single_idle_busy", 32'(busy_o), 32'd0);
      cyc();
      chk("single_pop", 32'(bus.pop_o), 32'd1);
      chk("single_pop_busy", 32'(busy_o), 32'd1);
      cyc();
      chk("single_capt_pop", 32'(bus.pop_o), 32'd0);
      chk("single_capt_req", 32'(bus.ks_req_o), 32'd0);
      chk("single_capt_vld", 32'(bus.pt_valid_o), 32'd0);
      cyc();
      chk("single_ks_req", 32'(bus.ks_req_o), 32'd1);
      cyc();
      chk("single_out_vld", 32'(bus.pt_valid_o), 32'd1);
      chk("single_out_data", 32'(bus.pt_data_o), 32'h99);
      cyc();
      chk("single_cnt", 32'(byte_cnt_o), 32'd1);
      chk("single_done_busy", 32'(busy_o), 32'd0);

      // Backpressure: data held for 10 stalled cycles, no extra pops
      bus.pt_ready_i = 1'b0;
      bus.ks_byte_i  = 8'($urandom);
      push(8'($urandom));
      push(8'($urandom));
      for (int i = 0; i < 10 && !bus.pt_valid_o; i++) cyc();
      chk("bp_reach_out", 32'(bus.pt_valid_o), 32'd1);
      hold = bus.pt_data_o;
      cnt_before = exp_cnt;
      for (int i = 0; i < 10; i++) begin
         bus.ks_byte_i = 8'($urandom);
         cyc();
         chk("bp_valid", 32'(bus.pt_valid_o), 32'd1);
         chk("bp_data", 32'(bus.pt_data_o), 32'(hold));
         chk("bp_pop", 32'(bus.pop_o), 32'd0);
         chk("bp_cnt", 32'(byte_cnt_o), 32'(cnt_before));
      end
      bus.pt_ready_i = 1'b1;
      cyc();
      chk("bp_cnt_hs", 32'(byte_cnt_o), 32'(cnt_before + 16'd1));
      wait_quiet(50, "bp_drain");

      // Keystream stall: 7 cycles without ks_valid, transfer on the 8th
      bus.ks_valid_i = 1'b0;
      push(8'($urandom));
      for (int i = 0; i < 10 && !bus.ks_req_o; i++) cyc();
      for (int i = 0; i < 7; i++) begin
         chk("stall_req", 32'(bus.ks_req_o), 32'd1);
         bus.ks_byte_i = 8'($urandom);
         cyc();
      end
      bus.ks_valid_i = 1'b1;
      bus.ks_byte_i  = 8'($urandom);
      chk("stall_req8", 32'(bus.ks_req_o), 32'd1);
      cyc();
      chk("stall_out", 32'(bus.pt_valid_o), 32'd1);
      wait_quiet(50, "stall_drain");

      // Gating by ks_ready and en; dropping en mid-byte still completes it
      bus.ks_ready_i = 1'b0;
      push(8'($urandom));
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("gate_ksr_pop", 32'(bus.pop_o), 32'd0);
         chk("gate_ksr_busy", 32'(busy_o), 32'd0);
      end
      bus.ks_ready_i = 1'b1;
      en_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("gate_en_pop", 32'(bus.pop_o), 32'd0);
         chk("gate_en_busy", 32'(busy_o), 32'd0);
      end
      en_i = 1'b1;
      bus.ks_valid_i = 1'b0;
      for (int i = 0; i < 10 && !bus.ks_req_o; i++) cyc();
      chk("gate_reach_ks", 32'(bus.ks_req_o), 32'd1);
      cnt_before = exp_cnt;
      en_i = 1'b0;
      push(8'($urandom));
      repeat (3) cyc();
      bus.ks_valid_i = 1'b1;
      for (int i = 0; i < 10 && busy_o; i++) cyc();
      chk("gate_complete_busy", 32'(busy_o), 32'd0);
      chk("gate_complete_cnt", 32'(byte_cnt_o), 32'(cnt_before + 16'd1));
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("gate_idle_pop", 32'(bus.pop_o), 32'd0);
         chk("gate_idle_busy", 32'(busy_o), 32'd0);
      end
      en_i = 1'b1;
      wait_quiet(50, "gate_drain");

      // Reset in CAPT discards the byte; next byte decrypts normally
      push(8'($urandom));
      for (int i = 0; i < 10 && !bus.pop_o; i++) cyc();
      chk("rst_mid_pop", 32'(bus.pop_o), 32'd1);
      cyc();
      chk("rst_mid_capt_busy", 32'(busy_o), 32'd1);
      rst = 1'b1;
      exp_cnt = '0;
      cyc();
      ct_fly.delete();
      pt_exp.delete();
      chk_zero("rst_mid");
      rst = 1'b0;
      bus.ks_byte_i = 8'h5A;
      push(8'h0F);
      for (int i = 0; i < 10 && !bus.pt_valid_o; i++) cyc();
      chk("rst_after_data", 32'(bus.pt_data_o), 32'h55);
      wait_quiet(50, "rst_after_drain");
      chk("rst_after_cnt", 32'(byte_cnt_o), 32'd1);

      // Randomized traffic against the scoreboard
      rnd_traffic = 1'b1;
      for (int i = 0; i < 40; i++) push(8'($urandom));
      wait_quiet(2000, "rand_drain");
      rnd_traffic = 1'b0;
      bus.ks_valid_i = 1'b1;
      bus.pt_ready_i = 1'b1;

      // Sticky error flags and optional saturating counter
      err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0;
      pe_i = 1'b1; fe_i = 1'b1;
      cyc();
      pe_i = 1'b0; fe_i = 1'b0; bi_i = 1'b1; err_clr_i = 1'b1;
      cyc();
      bi_i = 1'b0; err_clr_i = 1'b0;
      chk("err_set_wins", 32'(err_flags_o), 32'b100);
`ifdef RX_DEC_ERRCNT_EN
      chk("err_cnt_inc_wins", 32'(err_cnt_o), 32'd2);
`else
      chk("err_cnt_off", 32'(err_cnt_o), 32'd0);
`endif
      err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0;
      chk("err_clr_flags", 32'(err_flags_o), 32'd0);
      chk("err_clr_cnt", 32'(err_cnt_o), 32'd0);

      exp_flags = '0;
      exp_ec    = 0;
      push(8'($urandom));
      push(8'($urandom));
      for (int i = 0; i < 300; i++) begin
         ev = 3'($urandom_range(1, 7));
         {bi_i, fe_i, pe_i} = ev;
         exp_flags = exp_flags | ev;
`ifdef RX_DEC_ERRCNT_EN
         exp_ec = (exp_ec + 1 > 255) ? 255 : exp_ec + 1;
`endif
         cyc();
         chk("err_cnt_run", 32'(err_cnt_o), 32'(exp_ec));
      end
      {bi_i, fe_i, pe_i} = 3'b000;
      chk("err_flags_sticky", 32'(err_flags_o), 32'(exp_flags));
`ifdef RX_DEC_ERRCNT_EN
      chk("err_cnt_sat", 32'(err_cnt_o), 32'd255);
`else
      chk("err_cnt_zero", 32'(err_cnt_o), 32'd0);
`endif
      wait_quiet(50, "err_traffic_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
